// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
//   Shares one SDRAM burst controller between two clients and schedules
//   periodic auto-refresh. Only one controller operation (write burst,
//   read burst or refresh) is outstanding at a time. Clients are served
//   round-robin, and a due refresh always wins over both clients.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_init_done             controller init complete (level)
//   i_cX_req/rd/addr        client X request level, direction (1=read), address
//   o_cX_gnt                one-cycle pulse when client X's request is issued
//   o_cX_done               one-cycle pulse when client X's operation completes
//   o_wr_req/o_rd_req       one-cycle burst requests to the controller
//   o_ref_req               one-cycle refresh request to the controller
//   o_burst_addr            address latched for the current operation
//   i_wr/rd/ref_done        controller completion pulses
//   o_busy                  high whenever the arbiter is not idle
//   o_err                   sticky watchdog timeout flag
//
// Optional feature (macro SDRAM_ARB_WDOG_EN)
//   Defined: an operation whose completion does not arrive within WDOG_CYC
//   cycles is abandoned; o_err is set (sticky) and the client, if any, still
//   receives its done pulse. Undefined: waits forever, o_err tied low.

module sdram_req_arbiter #(
    parameter int RAM_ADDR_W = 24,
    parameter int REF_PERIOD = 780,
    parameter int WDOG_CYC   = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_init_done,
    input  logic                  i_c0_req,
    input  logic                  i_c0_rd,
    input  logic [RAM_ADDR_W-1:0] i_c0_addr,
    output logic                  o_c0_gnt,
    output logic                  o_c0_done,
    input  logic                  i_c1_req,
    input  logic                  i_c1_rd,
    input  logic [RAM_ADDR_W-1:0] i_c1_addr,
    output logic                  o_c1_gnt,
    output logic                  o_c1_done,
    output logic                  o_wr_req,
    output logic                  o_rd_req,
    output logic                  o_ref_req,
    output logic [RAM_ADDR_W-1:0] o_burst_addr,
    input  logic                  i_wr_done,
    input  logic                  i_rd_done,
    input  logic                  i_ref_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int               REF_W    = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_REFRESH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_pending;
    logic             ref_expire;
    logic             ref_due;
    logic             rr_c1;
    logic             cur_id;
    logic             cur_rd;
    logic             pick_c1;
    logic             any_req;
    logic             op_done;
    logic             wdog_expire;
    logic             take_op;
    logic             take_ref;
    logic             leave_wait;
    logic             c0_done_q;
    logic             c1_done_q;
    logic             ref_req_q;
    logic             busy_q;

    assign any_req = i_c0_req | i_c1_req;
    // rr_c1 = 1 means client 1 was not served last and wins a tie.
    assign pick_c1 = i_c1_req & (~i_c0_req | rr_c1);

    // The expiry cycle itself already counts as due, so a client request
    // arriving in the same cycle cannot slip in ahead of the refresh.
    assign ref_expire = (state != S_WAIT_INIT) && (ref_cnt == REF_LAST);
    assign ref_due    = ref_pending | ref_expire;

    // Only the completion matching the latched direction ends the burst.
    assign op_done = cur_rd ? i_rd_done : i_wr_done;

    assign take_op    = (state == S_IDLE) && (state_nxt == S_ISSUE);
    assign take_ref   = (state == S_IDLE) && (state_nxt == S_REFRESH);
    assign leave_wait = (state == S_WAIT_DONE) && (state_nxt == S_IDLE);

`ifdef SDRAM_ARB_WDOG_EN
    localparam int                WDOG_W    = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_run;
    logic              wdog_hit;
    logic              err_q;

    assign wdog_run    = (state == S_WAIT_DONE) || (state == S_REFRESH);
    assign wdog_expire = wdog_run && (wdog_cnt == WDOG_LAST);
    // A completion landing on the very last allowed cycle is not an error.
    assign wdog_hit    = wdog_expire &&
                         !(((state == S_WAIT_DONE) && op_done) ||
                           ((state == S_REFRESH) && i_ref_done));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (wdog_run) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end else begin
                wdog_cnt <= '0;
            end
            if (wdog_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_err = err_q;
`else
    assign wdog_expire = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_INIT: begin
                if (i_init_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (ref_due) begin
                    state_nxt = S_REFRESH;
                end else if (any_req) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (op_done || wdog_expire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_REFRESH: begin
                if (i_ref_done || wdog_expire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_WAIT_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_WAIT_INIT;
            ref_cnt      <= '0;
            ref_pending  <= 1'b0;
            rr_c1        <= 1'b0;
            cur_id       <= 1'b0;
            cur_rd       <= 1'b0;
            o_burst_addr <= '0;
            c0_done_q    <= 1'b0;
            c1_done_q    <= 1'b0;
            ref_req_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy_q    <= (state_nxt != S_IDLE);
            ref_req_q <= take_ref;
            c0_done_q <= leave_wait && !cur_id;
            c1_done_q <= leave_wait && cur_id;

            // Free-running refresh timer, held at zero until init completes.
            if ((state == S_WAIT_INIT) || (ref_cnt == REF_LAST)) begin
                ref_cnt <= '0;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            // Clearing on refresh entry wins, so an expiry that coincides
            // with an already-pending refresh never queues a second one.
            if (take_ref) begin
                ref_pending <= 1'b0;
            end else if (ref_expire) begin
                ref_pending <= 1'b1;
            end

            if (take_op) begin
                cur_id       <= pick_c1;
                cur_rd       <= pick_c1 ? i_c1_rd : i_c0_rd;
                o_burst_addr <= pick_c1 ? i_c1_addr : i_c0_addr;
            end

            if (leave_wait) begin
                rr_c1 <= ~cur_id;
            end
        end
    end

    assign o_c0_gnt  = (state == S_ISSUE) && !cur_id;
    assign o_c1_gnt  = (state == S_ISSUE) && cur_id;
    assign o_wr_req  = (state == S_ISSUE) && !cur_rd;
    assign o_rd_req  = (state == S_ISSUE) && cur_rd;
    assign o_ref_req = ref_req_q;
    assign o_c0_done = c0_done_q;
    assign o_c1_done = c1_done_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter
//   Scoreboard bench for sdram_req_arbiter. Expected grants and done pulses
//   are queued as stimulus is driven; a negedge monitor pops and compares
//   them when the DUT produces them. A background responder answers every
//   refresh request after a fixed latency.

module tb_sdram_req_arbiter;

    localparam int AW      = 24;
    localparam int RP      = 100;
    localparam int WD      = 64;
    localparam int REF_LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_init_done;
    logic          i_c0_req, i_c0_rd, i_c1_req, i_c1_rd;
    logic [AW-1:0] i_c0_addr, i_c1_addr;
    logic          o_c0_gnt, o_c0_done, o_c1_gnt, o_c1_done;
    logic          o_wr_req, o_rd_req, o_ref_req;
    logic [AW-1:0] o_burst_addr;
    logic          i_wr_done, i_rd_done, i_ref_done;
    logic          o_busy, o_err;

    sdram_req_arbiter #(
        .RAM_ADDR_W (AW),
        .REF_PERIOD (RP),
        .WDOG_CYC   (WD)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_init_done  (i_init_done),
        .i_c0_req     (i_c0_req),
        .i_c0_rd      (i_c0_rd),
        .i_c0_addr    (i_c0_addr),
        .o_c0_gnt     (o_c0_gnt),
        .o_c0_done    (o_c0_done),
        .i_c1_req     (i_c1_req),
        .i_c1_rd      (i_c1_rd),
        .i_c1_addr    (i_c1_addr),
        .o_c1_gnt     (o_c1_gnt),
        .o_c1_done    (o_c1_done),
        .o_wr_req     (o_wr_req),
        .o_rd_req     (o_rd_req),
        .o_ref_req    (o_ref_req),
        .o_burst_addr (o_burst_addr),
        .i_wr_done    (i_wr_done),
        .i_rd_done    (i_rd_done),
        .i_ref_done   (i_ref_done),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic          id;
        logic          rd;
        logic [AW-1:0] addr;
    } gnt_t;

    typedef struct {
        logic id;
        int   at;
    } done_t;

    gnt_t  gnt_q[$];
    done_t done_q[$];

    int n_issue      = 0;
    int n_ref        = 0;
    int ref_cyc      = -1;
    int ref_done_cyc = -1;
    int n_err_seen   = 0;

    // Output monitor
    always @(negedge clk) begin : mon
        gnt_t  g;
        done_t d;
        if (!rst) begin
            if (o_c0_gnt || o_c1_gnt || o_wr_req || o_rd_req) begin
                n_issue++;
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected_qsize", 32'(gnt_q.size()), 32'd1);
                end else begin
                    g = gnt_q.pop_front();
                    chk("gnt_vec", 32'({o_c0_gnt, o_c1_gnt, o_wr_req, o_rd_req}),
                        32'({!g.id, g.id, !g.rd, g.rd}));
                    chk("burst_addr", 32'(o_burst_addr), 32'(g.addr));
                end
            end
            if (o_c0_done || o_c1_done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected_qsize", 32'(done_q.size()), 32'd1);
                end else begin
                    d = done_q.pop_front();
                    chk("done_id", 32'({o_c0_done, o_c1_done}), 32'({!d.id, d.id}));
                    chk("done_cyc", 32'(cyc), 32'(d.at));
                end
            end
            if (o_ref_req) begin
                n_ref++;
                ref_cyc = cyc;
            end
            if (o_err) n_err_seen++;
        end
    end

    // Refresh responder: completes each refresh REF_LAT cycles after the request.
    initial begin
        i_ref_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && o_ref_req) begin
                repeat (REF_LAT) @(posedge clk);
                #1;
                i_ref_done   = 1'b1;
                ref_done_cyc = cyc;
                @(posedge clk);
                #1;
                i_ref_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        i_init_done = 1'b0;
        i_c0_req    = 1'b0;
        i_c1_req    = 1'b0;
        i_wr_done   = 1'b0;
        i_rd_done   = 1'b0;
        tick(3);
        rst = 1'b0;
        gnt_q.delete();
        done_q.delete();
    endtask

    task automatic wait_issue(input string tag, output int at);
        int   n    = 0;
        logic seen = 1'b0;
        at = -1;
        while (!seen && n < 600) begin
            if (o_c0_gnt || o_c1_gnt) begin
                seen = 1'b1;
                at   = cyc;
            end else begin
                tick();
                n++;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic pulse_done(input logic rd, input logic id, input logic expect_done);
        if (rd) i_rd_done = 1'b1;
        else    i_wr_done = 1'b1;
        if (expect_done) done_q.push_back('{id: id, at: cyc + 1});
        tick();
        i_rd_done = 1'b0;
        i_wr_done = 1'b0;
    endtask

    initial begin
        int w, i0, g, i_base, r_base;

        // Reset state, then a long init wait with client 0 requesting
        rst         = 1'b1;
        i_init_done = 1'b0;
        i_c0_req    = 1'b1;
        i_c0_rd     = 1'b0;
        i_c0_addr   = 24'h000100;
        i_c1_req    = 1'b1;
        i_c1_rd     = 1'b1;
        i_c1_addr   = 24'h00FFFF;
        i_wr_done   = 1'b0;
        i_rd_done   = 1'b0;
        tick(2);
        chk("rst_outputs", 32'({o_c0_gnt, o_c1_gnt, o_c0_done, o_c1_done, o_wr_req,
                                o_rd_req, o_ref_req, o_busy, o_err}), 32'd0);
        chk("rst_addr", 32'(o_burst_addr), 32'd0);
        i_c1_req = 1'b0;
        rst      = 1'b0;
        i_base   = n_issue;
        r_base   = n_ref;
        tick(2000);
        chk("init_no_issue", 32'(n_issue - i_base), 32'd0);
        chk("init_no_ref", 32'(n_ref - r_base), 32'd0);
        chk("init_busy", 32'(o_busy), 32'd1);

        // Single client 0 write
        gnt_q.push_back('{id: 1'b0, rd: 1'b0, addr: 24'h000100});
        i_init_done = 1'b1;
        w = cyc;
        wait_issue("t2_issue_seen", g);
        chk("t2_gnt_cyc", 32'(g), 32'(w + 2));
        chk("t2_wr_with_gnt", 32'({o_c0_gnt, o_wr_req}), 32'b11);
        i_c0_req = 1'b0;
        tick(10);
        pulse_done(1'b0, 1'b0, 1'b1);
        chk("t2_idle_after_done", 32'(o_busy), 32'd0);

        // Round-robin with both clients held high; stray write done during a read
        do_reset();
        i_c0_addr = 24'hABCDE0;
        i_c1_addr = 24'h123456;
        i_c0_rd   = 1'b0;
        i_c1_rd   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gnt_q.push_back('{id: k[0], rd: k[0], addr: k[0] ? 24'h123456 : 24'hABCDE0});
        end
        i_init_done = 1'b1;
        i_c0_req    = 1'b1;
        i_c1_req    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_issue("t3_issue_seen", g);
            chk("t3_rr_order", 32'(o_c1_gnt), 32'(k % 2));
            if (k == 3) begin
                i_c0_req = 1'b0;
                i_c1_req = 1'b0;
            end
            tick(3);
            if (k % 2 == 0) begin
                pulse_done(1'b0, 1'b0, 1'b1);
            end else begin
                pulse_done(1'b0, 1'b1, 1'b0);
                chk("t3_stray_ignored_busy", 32'(o_busy), 32'd1);
                tick(2);
                pulse_done(1'b1, 1'b1, 1'b1);
            end
        end
        tick(3);
        chk("t3_gnt_q_empty", 32'(gnt_q.size()), 32'd0);

        // Refresh expiry coinciding with a client 1 request
        do_reset();
        i_init_done = 1'b1;
        w  = cyc;
        i0 = w + 1;
        tick(100);
        i_c1_req  = 1'b1;
        i_c1_rd   = 1'b0;
        i_c1_addr = 24'h00BEEF;
        gnt_q.push_back('{id: 1'b1, rd: 1'b0, addr: 24'h00BEEF});
        tick();
        chk("t4_ref_first", 32'({o_ref_req, o_c1_gnt}), 32'b10);
        chk("t4_ref_cyc", 32'(cyc), 32'(i0 + RP));
        wait_issue("t4_issue_seen", g);
        chk("t4_gnt_after_ref", 32'(g), 32'(ref_done_cyc + 2));
        i_c1_req = 1'b0;
        tick(5);
        pulse_done(1'b0, 1'b1, 1'b1);
        tick(2);

`ifndef SDRAM_ARB_WDOG_EN
        // Long transaction spanning two timer expiries
        do_reset();
        i_c0_req  = 1'b1;
        i_c0_rd   = 1'b0;
        i_c0_addr = 24'h555555;
        gnt_q.push_back('{id: 1'b0, rd: 1'b0, addr: 24'h555555});
        i_init_done = 1'b1;
        w  = cyc;
        i0 = w + 1;
        r_base = n_ref;
        wait_issue("t5_issue_seen", g);
        chk("t5_gnt_cyc", 32'(g), 32'(i0 + 1));
        i_c0_req = 1'b0;
        tick(250);
        pulse_done(1'b0, 1'b0, 1'b1);
        tick(47);
        chk("t5_one_ref", 32'(n_ref - r_base), 32'd1);
        chk("t5_ref_after_done", 32'(ref_cyc), 32'(i0 + 253));
        tick();
        chk("t5_phase_kept", 32'({o_ref_req, 32'(cyc) == 32'(i0 + 3 * RP)}), 32'b11);
        tick(8);
        chk("t5_err_tied_low", 32'(n_err_seen), 32'd0);
`else
        // Watchdog: read completion never arrives
        do_reset();
        i_c0_req  = 1'b1;
        i_c0_rd   = 1'b1;
        i_c0_addr = 24'h0F0F0F;
        gnt_q.push_back('{id: 1'b0, rd: 1'b1, addr: 24'h0F0F0F});
        i_init_done = 1'b1;
        wait_issue("t6_issue_seen", g);
        i_c0_req = 1'b0;
        done_q.push_back('{id: 1'b0, at: g + WD + 1});
        tick(WD);
        chk("t6_no_err_early", 32'({o_err, o_c0_done}), 32'd0);
        tick();
        chk("t6_timeout", 32'({o_err, o_c0_done}), 32'b11);
        tick(20);
        chk("t6_err_sticky", 32'(o_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_err_cleared", 32'(o_err), 32'd0);
        tick();
        rst = 1'b0;
`endif

        chk("end_gnt_q_empty", 32'(gnt_q.size()), 32'd0);
        chk("end_done_q_empty", 32'(done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
